// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_arb_pkg;

    typedef logic [1:0] req_idx_t;

    localparam int MAX_NUM_REQ             = 4;
    localparam int DEFAULT_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/mem_arb_route_fifo.sv
// Route FIFO: remembers which requester owns each in-flight memory request.
// Registered read (head is always mem_q[rd_ptr_q]), no fall-through.
module mem_arb_route_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_OUTSTANDING,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  req_idx_t data_i,
    input  logic     pop_i,
    output req_idx_t data_o,
    output logic     full_o,
    output logic     empty_o
);

    req_idx_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters, with
// in-order response routing. Define MEM_ARB_LOCK_EN to add lock_i bus locking.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ         = MAX_NUM_REQ,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            lock_i,
`endif
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic                          mem_we_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic                          busy_o,
    output logic                          spurious_o
);

    // Handshake: mem_req_o & mem_gnt_i in the same cycle pushes the winner
    // into the route FIFO; mem_rvalid_i pops its head, one response per grant.

    req_idx_t               rr_q;
    req_idx_t               winner;
    req_idx_t               next_rr;
    req_idx_t               route_head;
    logic [NUM_REQ-1:0]     eligible;
    logic                   found;
    logic                   hs;
    logic                   pop;
    logic                   route_full;
    logic                   route_empty;
    logic                   lock_eff;
    int                     idx;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [DATA_WIDTH-1:0]  win_wdata;
    logic                   win_we;
    logic [ADDR_WIDTH-1:0]  hold_addr_q;
    logic [DATA_WIDTH-1:0]  hold_wdata_q;
    logic                   hold_we_q;

`ifdef MEM_ARB_LOCK_EN
    logic     lock_q;
    req_idx_t owner_q;

    // The lock only binds while its owner keeps both request and lock raised.
    assign lock_eff = lock_q & req_i[owner_q] & lock_i[owner_q];
    assign eligible = lock_eff ? (NUM_REQ'(1) << owner_q) : req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (hs) begin
            lock_q  <= lock_i[winner];
            owner_q <= winner;
        end else if (lock_q && !req_i[owner_q]) begin
            lock_q  <= 1'b0;
        end
    end
`else
    assign lock_eff = 1'b0;
    assign eligible = req_i;
`endif

    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && eligible[idx[1:0]]) begin
                found  = 1'b1;
                winner = req_idx_t'(idx);
            end
        end
    end

    assign next_rr   = req_idx_t'((int'(winner) + 1) % NUM_REQ);
    assign win_addr  = addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_wdata = wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    assign win_we    = we_i[winner];

    // route_full comes from the registered count, so a pop never unblocks
    // the request in the same cycle.
    assign mem_req_o = rst_ni & (|req_i) & ~route_full;
    assign hs        = mem_req_o & mem_gnt_i;
    assign pop       = rst_ni & mem_rvalid_i & ~route_empty;

    assign mem_addr_o  = !rst_ni ? '0 : (mem_req_o ? win_addr  : hold_addr_q);
    assign mem_wdata_o = !rst_ni ? '0 : (mem_req_o ? win_wdata : hold_wdata_q);
    assign mem_we_o    = rst_ni & (mem_req_o ? win_we : hold_we_q);
    assign rdata_o     = rst_ni ? mem_rdata_i : '0;
    assign busy_o      = rst_ni & ~route_empty;
    assign spurious_o  = rst_ni & mem_rvalid_i & route_empty;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (hs)  gnt_o[winner]        = 1'b1;
        if (pop) rvalid_o[route_head] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q         <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_we_q    <= 1'b0;
        end else begin
            if (hs && !lock_eff) rr_q <= next_rr;
            if (mem_req_o) begin
                hold_addr_q  <= win_addr;
                hold_wdata_q <= win_wdata;
                hold_we_q    <= win_we;
            end
        end
    end

    mem_arb_route_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (route_head),
        .full_o  (route_full),
        .empty_o (route_empty)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed vectors, literal expectations and a
// queue-based reference model compared every cycle.
module tb_mem_req_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MO  = 4;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  addr;
    logic [NR-1:0]     we;
    logic [NR*DW-1:0]  wdata;
    logic [NR-1:0]     lock;
    logic [NR-1:0]     lock_nxt;
    logic [NR-1:0]     gnt_o;
    logic [NR-1:0]     rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              mem_req_o;
    logic              mem_gnt;
    logic [AW-1:0]     mem_addr_o;
    logic              mem_we_o;
    logic [DW-1:0]     mem_wdata_o;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;
    logic              busy_o;
    logic              spurious_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0]  exp_q[$];
    int          m_rr;
    logic [31:0] m_addr_h;
    logic [31:0] m_wdata_h;
    logic        m_we_h;
    logic        m_lock;
    int          m_owner;

    mem_req_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .addr_i       (addr),
        .we_i         (we),
        .wdata_i      (wdata),
`ifdef MEM_ARB_LOCK_EN
        .lock_i       (lock),
`endif
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy_o),
        .spurious_o   (spurious_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: new inputs just after the rising edge, return at the falling edge.
    task automatic cyc(input logic [3:0] r, input logic g, input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        req        = r;
        mem_gnt    = g;
        mem_rvalid = rv;
        mem_rdata  = rd;
        lock       = lock_nxt;
        @(negedge clk);
    endtask

    function automatic logic [31:0] addr_of(input int k);
        return 32'h1000_0000 + 32'(k * 16);
    endfunction

    // Compare process: model the outputs from the arbitration rules and an
    // ordered queue of outstanding owners, then advance the model.
    always @(negedge clk) begin : cmp
        logic [3:0]  elig;
        int          w;
        logic        mreq, hs, pop, lk;
        logic [3:0]  e_gnt, e_rv;
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        if (!rst_n) begin
            check("rst_ctrl", {gnt_o, rvalid_o, mem_req_o, mem_we_o, busy_o, spurious_o}, 64'h0);
            check("rst_data", {mem_addr_o, mem_wdata_o}, 64'h0);
            check("rst_rdata", rdata_o, 64'h0);
            exp_q.delete();
            m_rr = 0; m_addr_h = '0; m_wdata_h = '0; m_we_h = 1'b0;
            m_lock = 1'b0; m_owner = 0;
        end else begin
            elig = req;
            lk   = 1'b0;
`ifdef MEM_ARB_LOCK_EN
            lk = m_lock && req[m_owner] && lock[m_owner];
            if (lk) elig = 4'b0001 << m_owner;
`endif
            w = -1;
            for (int k = 0; k < NR; k++)
                if (w < 0 && elig[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            mreq    = (req != 0) && (exp_q.size() < MO);
            hs      = mreq && mem_gnt;
            e_addr  = mreq ? addr[w*AW +: AW]  : m_addr_h;
            e_wdata = mreq ? wdata[w*DW +: DW] : m_wdata_h;
            e_we    = mreq ? we[w]             : m_we_h;
            e_gnt   = hs ? (4'b0001 << w) : 4'b0000;
            pop     = mem_rvalid && (exp_q.size() > 0);
            e_rv    = pop ? (4'b0001 << exp_q[0]) : 4'b0000;
            check("mdl_mem_req", mem_req_o, mreq);
            check("mdl_gnt", gnt_o, e_gnt);
            check("mdl_addr", mem_addr_o, e_addr);
            check("mdl_wdata", mem_wdata_o, e_wdata);
            check("mdl_we", mem_we_o, e_we);
            check("mdl_rvalid", rvalid_o, e_rv);
            if (pop) check("mdl_rdata", rdata_o, mem_rdata);
            check("mdl_spurious", spurious_o, mem_rvalid && exp_q.size() == 0);
            check("mdl_busy", busy_o, exp_q.size() != 0);
            if (pop) void'(exp_q.pop_front());
            if (hs) begin
                exp_q.push_back(w[1:0]);
                if (!lk) m_rr = (w + 1) % NR;
                m_lock  = lock[w];
                m_owner = w;
            end else if (m_lock && !req[m_owner]) begin
                m_lock = 1'b0;
            end
            if (mreq) begin
                m_addr_h = e_addr; m_wdata_h = e_wdata; m_we_h = e_we;
            end
        end
    end

    initial begin
        logic [3:0] seq[4];
        rst_n = 1'b0; req = 4'b1111; mem_gnt = 1'b1; mem_rvalid = 1'b0;
        mem_rdata = '0; lock = '0; lock_nxt = '0; we = 4'b1010;
        for (int k = 0; k < NR; k++) begin
            addr[k*AW +: AW]  = addr_of(k);
            wdata[k*DW +: DW] = 32'hD000_0000 + 32'(k);
        end
        @(negedge clk);
        check("rst_gnt", gnt_o, 64'h0);
        check("rst_mem_req", mem_req_o, 64'h0);
        @(posedge clk); #1; rst_n = 1'b1; req = '0; mem_gnt = 1'b0;

        // Stalled memory: no grant, address held; then 0 and 2 in order
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0101, 1'b0, 1'b0, 32'h0);
            check("stall_gnt", gnt_o, 64'h0);
            check("stall_addr", mem_addr_o, addr_of(0));
        end
        cyc(4'b0101, 1'b1, 1'b0, 32'h0);
        check("release_gnt0", gnt_o, 64'b0001);
        cyc(4'b0101, 1'b1, 1'b0, 32'h0);
        check("release_gnt2", gnt_o, 64'b0100);
        check("busy_two_out", busy_o, 64'h1);

        // Reset with two requests outstanding discards them
        @(posedge clk); #1; rst_n = 1'b0; req = '0; mem_gnt = 1'b0;
        @(negedge clk);
        check("rst_busy", busy_o, 64'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        cyc(4'b0000, 1'b0, 1'b1, 32'h55);
        check("post_rst_spurious", spurious_o, 64'h1);
        check("post_rst_rvalid", rvalid_o, 64'h0);
        cyc(4'b0000, 1'b0, 1'b0, 32'h0);
        check("spurious_single", spurious_o, 64'h0);

        // Full rotation, draining one response per cycle
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        cyc(4'b1111, 1'b1, 1'b0, 32'h0);
        check("rr_gnt_0", gnt_o, 64'b0001);
        for (int i = 1; i < 5; i++) begin
            cyc(4'b1111, 1'b1, 1'b1, 32'(i));
            check("rr_gnt", gnt_o, 64'(seq[i % 4]));
            check("rr_rvalid", rvalid_o, 64'(seq[i - 1]));
        end
        cyc(4'b0000, 1'b0, 1'b1, 32'h0);
        check("rr_drain", rvalid_o, 64'b0001);
        cyc(4'b0000, 1'b0, 1'b0, 32'h0);
        check("rr_idle_busy", busy_o, 64'h0);

        // Fill the route FIFO: requests blocked until the pop has registered
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            cyc(4'b1111, 1'b1, 1'b0, 32'h0);
            check("fill_gnt", gnt_o, 64'(seq[i]));
        end
        cyc(4'b1111, 1'b1, 1'b0, 32'h0);
        check("full_mem_req", mem_req_o, 64'h0);
        check("full_busy", busy_o, 64'h1);
        check("full_held_addr", mem_addr_o, addr_of(0));
        cyc(4'b1111, 1'b1, 1'b1, 32'h11);
        check("full_pop_rvalid", rvalid_o, 64'b0010);
        check("full_pop_no_req", mem_req_o, 64'h0);
        cyc(4'b1111, 1'b0, 1'b0, 32'h0);
        check("full_req_rises", mem_req_o, 64'h1);
        for (int i = 1; i < 4; i++) begin
            cyc(4'b0000, 1'b0, 1'b1, 32'h0);
            check("full_drain", rvalid_o, 64'(seq[i]));
        end

        // Grants to 2, 0, 3, then routed responses A, B, C
        cyc(4'b0100, 1'b1, 1'b0, 32'h0); check("route_gnt2", gnt_o, 64'b0100);
        cyc(4'b0001, 1'b1, 1'b0, 32'h0); check("route_gnt0", gnt_o, 64'b0001);
        cyc(4'b1000, 1'b1, 1'b0, 32'h0); check("route_gnt3", gnt_o, 64'b1000);
        cyc(4'b0000, 1'b0, 1'b1, 32'hA);
        check("route_rv_a", rvalid_o, 64'b0100); check("route_rd_a", rdata_o, 64'hA);
        cyc(4'b0000, 1'b0, 1'b1, 32'hB);
        check("route_rv_b", rvalid_o, 64'b0001); check("route_rd_b", rdata_o, 64'hB);
        cyc(4'b0000, 1'b0, 1'b1, 32'hC);
        check("route_rv_c", rvalid_o, 64'b1000); check("route_rd_c", rdata_o, 64'hC);
        cyc(4'b0000, 1'b0, 1'b0, 32'h0);
        check("route_idle_busy", busy_o, 64'h0);

        // Response with nothing outstanding
        cyc(4'b0000, 1'b0, 1'b1, 32'h77);
        check("spurious_pulse", spurious_o, 64'h1);
        check("spurious_rvalid", rvalid_o, 64'h0);
        cyc(4'b0000, 1'b0, 1'b0, 32'h0);
        check("spurious_clear", spurious_o, 64'h0);

`ifdef MEM_ARB_LOCK_EN
        // Requester 1 locks the port for three handshakes, then releases
        cyc(4'b0001, 1'b1, 1'b0, 32'h0);
        check("lock_pre_gnt", gnt_o, 64'b0001);
        cyc(4'b0000, 1'b0, 1'b1, 32'h0);
        lock_nxt = 4'b0010;
        cyc(4'b1111, 1'b1, 1'b0, 32'h0);
        check("lock_gnt_a", gnt_o, 64'b0010);
        cyc(4'b1111, 1'b1, 1'b1, 32'h0);
        check("lock_gnt_b", gnt_o, 64'b0010);
        cyc(4'b1111, 1'b1, 1'b1, 32'h0);
        check("lock_gnt_c", gnt_o, 64'b0010);
        lock_nxt = 4'b0000;
        cyc(4'b1111, 1'b1, 1'b1, 32'h0);
        check("lock_release_gnt", gnt_o, 64'b0100);
        cyc(4'b0000, 1'b0, 1'b1, 32'h0);
        cyc(4'b0000, 1'b0, 1'b0, 32'h0);
        check("lock_idle_busy", busy_o, 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..4; requester index is 2 bits).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, read/write data width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the response-route FIFO (granted requests awaiting rvalid).
REQ-005 SHALL have ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request.
- addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester address, packed; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- we_i  in  NUM_REQ  per-requester write enable.
- wdata_i  in  NUM_REQ*DATA_WIDTH  per-requester write data, packed.
- gnt_o  out  NUM_REQ  one-hot grant.
- rvalid_o  out  NUM_REQ  one-hot response valid.
- rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_we_o  out  1  memory write enable.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rvalid_i  in  1  memory response, exactly one per granted request, in order.
- mem_rdata_i  in  DATA_WIDTH  memory response data.
- busy_o  out  1  at least one outstanding request.
- spurious_o  out  1  single-cycle pulse on an unexpected response.

Function
REQ-006 SHALL select a winner among asserted req_i combinationally, round-robin, searching upward (with wrap) from registered pointer rr_q.
REQ-007 SHALL drive mem_req_o = |req_i & ~route_full; mem_addr_o/mem_we_o/mem_wdata_o SHALL be the winner's fields, held while mem_req_o is low.
REQ-008 SHALL assert gnt_o[winner] only in a cycle with mem_req_o & mem_gnt_i; all other gnt_o bits SHALL be 0.
REQ-009 On a handshake, rr_q SHALL load (winner+1) mod NUM_REQ; without a handshake, rr_q SHALL hold.
REQ-010 On a handshake, the winner index SHALL be pushed into the route FIFO.
REQ-011 On mem_rvalid_i with the FIFO non-empty, the head index SHALL be popped and rvalid_o[head] asserted in the same cycle, with rdata_o = mem_rdata_i.
REQ-012 Simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-013 route_full SHALL be computed from the registered count, so a same-cycle pop SHALL NOT unblock mem_req_o.
REQ-014 mem_rvalid_i with the FIFO empty SHALL assert spurious_o for one cycle, SHALL set no rvalid_o bit, and SHALL leave state unchanged.
REQ-015 busy_o SHALL equal (count != 0), from the registered count.
REQ-016 Minimum latency SHALL be 0 cycles from req_i to gnt_o; the response latency SHALL be set by the memory only.

Reset
REQ-017 Reset SHALL clear rr_q, the FIFO pointers and the count.
REQ-018 While in reset, every output SHALL be 0.
REQ-019 A reset asserted with requests outstanding SHALL discard them, and responses arriving after reset SHALL be treated as spurious.

Configuration
REQ-020 With macro MEM_ARB_LOCK_EN defined, the block SHALL add input lock_i (NUM_REQ).
REQ-021 With MEM_ARB_LOCK_EN defined, a handshake whose winner has lock_i set SHALL set lock_q and owner_q.
REQ-022 While lock_q is set, only owner_q SHALL be eligible for arbitration, and rr_q SHALL NOT advance.
REQ-023 With MEM_ARB_LOCK_EN defined, lock_q SHALL clear on a handshake where lock_i[owner_q]=0, or when req_i[owner_q]=0.
REQ-024 Without MEM_ARB_LOCK_EN, the lock_i port and its logic SHALL be absent, and arbitration SHALL be pure round-robin.

Structure
REQ-025 Package mem_arb_pkg SHALL hold the requester-index typedef (2 bits) and the localparams for the maximum NUM_REQ and the default MAX_OUTSTANDING.
REQ-026 The route FIFO SHALL be a sub-module, mem_arb_route_fifo: DATA 2 bits, DEPTH MAX_OUTSTANDING, non-fall-through, asynchronous active-low reset.

Verification
REQ-027 Bench: req_i=4'b1111, mem_gnt_i=1 constantly -> gnt_o sequence 0001, 0010, 0100, 1000, 0001.
REQ-028 Bench: req_i=4'b0101, mem_gnt_i held 0 for 3 cycles -> gnt_o=0 and mem_addr_o stable; on release, requester 0 is granted and then requester 2.
REQ-029 Bench: 4 grants with no rvalid -> mem_req_o=0 and busy_o=1; one rvalid -> rvalid_o to the first grantee, and mem_req_o rises the next cycle.
REQ-030 Bench: grants to 2, 0, 3, then 3 rvalids with rdata 0xA, 0xB, 0xC -> rvalid_o 0100/0xA, 0001/0xB, 1000/0xC; busy_o=0 afterwards.
REQ-031 Bench: mem_rvalid_i with an empty FIFO -> spurious_o=1 for one cycle and rvalid_o=0.
REQ-032 Bench (MEM_ARB_LOCK_EN): requester 1 holds lock_i=1 for 3 handshakes with req_i=1111 -> grants 0010, 0010, 0010, then 0100 after lock_i drops.
